// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared types, lane table and period helper for the traffic scheduler
// Purpose : FSM state type, lane count, per-lane speed multipliers and the
//           level-scaled lane period calculation.
// Ports   : none (package)
package traffic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_CRASH  = 2'd3
   } state_e;

   localparam int NUM_LANES = 6;
   localparam int PERIOD_W  = 24;
   localparam int CNT_W     = 20;
   localparam int HOLD_W    = 20;

   // Lane 0..5 correspond to rows 2,5,7,9,11,12.
   localparam logic [3:0] LANE_MULT [NUM_LANES] = '{4'd1, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1};

   // Each level halves the period; very high levels would reach zero, so clamp to
   // one to keep the lane strobing every cycle instead of never.
   function automatic logic [PERIOD_W-1:0] lane_period(input logic [PERIOD_W-1:0] base,
                                                        input logic [3:0]          mult,
                                                        input logic [1:0]          lvl);
      logic [PERIOD_W-1:0] p;
      p = (base * {20'd0, mult}) >> lvl;
      if (p == '0) p = {{(PERIOD_W-1){1'b0}}, 1'b1};
      return p;
   endfunction

endpackage

// File: rtl/traffic_scheduler_if.sv
// rtl/traffic_scheduler_if.sv - control/status bundle between game logic and the scheduler
// Purpose : groups game control inputs and scheduler status outputs.
// Signals : start, pause, collide, level_up (master -> slave)
//           shift_en[5:0], state[1:0], level[1:0], crash_active (slave -> master)
interface traffic_scheduler_if;
   logic       start;
   logic       pause;
   logic       collide;
   logic       level_up;
   logic [5:0] shift_en;
   logic [1:0] state;
   logic [1:0] level;
   logic       crash_active;

   modport master (
      output start, pause, collide, level_up,
      input  shift_en, state, level, crash_active
   );

   modport slave (
      input  start, pause, collide, level_up,
      output shift_en, state, level, crash_active
   );
endinterface

// File: rtl/traffic_scheduler_lane_timer.sv
// rtl/traffic_scheduler_lane_timer.sv - single lane shift counter
// Purpose : counts clocks while running and strobes on the last count of the period.
// Ports   : clk, reset_n (async active-low), run (count enable), clear (sync zero,
//           overrides run), period[23:0] (>= 1), strobe (combinational from counter).
module lane_timer
   import traffic_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                run,
   input  logic                clear,
   input  logic [PERIOD_W-1:0] period,
   output logic                strobe
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             at_end;

   assign at_end = ({{(PERIOD_W-CNT_W){1'b0}}, cnt_q} == (period - 1'b1));
   assign strobe = run & at_end;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (run)
         cnt_d = at_end ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/traffic_scheduler.sv
// rtl/traffic_scheduler.sv - game FSM and per-lane shift strobe generation
// Purpose : IDLE/RUN/PAUSED/CRASH game flow, speed level, crash hold timer and
//           six lane timers producing per-lane shift strobes.
// Ports   : clk, reset_n (async active-low), bus (traffic_scheduler_if.slave).
// Params  : BASE_PERIOD (lane-0 period at level 0), CRASH_HOLD (clocks in CRASH).
// Config  : TRAFFIC_SCHED_PAUSE_EN enables the pause input; when undefined the
//           pause input is ignored and PAUSED is never entered.
module traffic_scheduler
   import traffic_pkg::*;
#(
   parameter int BASE_PERIOD = 3000,
   parameter int CRASH_HOLD  = 50000
)(
   input  logic                 clk,
   input  logic                 reset_n,
   traffic_scheduler_if.slave   bus
);

   localparam logic [PERIOD_W-1:0] BASE_W    = PERIOD_W'(BASE_PERIOD);
   localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(CRASH_HOLD - 1);

   state_e              state_q, state_d;
   logic [1:0]          level_q, level_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                pause_eff;
   logic                lvl_up_take;
   logic                lane_run;
   logic                lane_clear;
   logic [NUM_LANES-1:0] lane_strobe;

`ifdef TRAFFIC_SCHED_PAUSE_EN
   assign pause_eff = bus.pause;
`else
   logic unused_pause;
   assign unused_pause = bus.pause;
   assign pause_eff    = 1'b0;
`endif

   // level_up only counts when neither collide nor pause claims the cycle, and
   // at level 3 it is a no-op, which also means no counter clear.
   assign lvl_up_take = (state_q == ST_RUN) && !bus.collide && !pause_eff &&
                        bus.level_up && (level_q != 2'd3);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (bus.start) state_d = ST_RUN;
         ST_RUN: begin
            if (bus.collide)     state_d = ST_CRASH;
            else if (pause_eff)  state_d = ST_PAUSED;
         end
         ST_PAUSED: if (!pause_eff) state_d = ST_RUN;
         ST_CRASH:  if (hold_q == HOLD_LAST) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Level and crash-hold datapath
   always_comb begin
      level_d = level_q;
      hold_d  = '0;              // zero outside CRASH so it starts at 0 on entry
      case (state_q)
         ST_IDLE: level_d = 2'd0;
         ST_RUN:  if (lvl_up_take) level_d = level_q + 2'd1;
         ST_CRASH: begin
            hold_d = hold_q + 1'b1;
            if (hold_q == HOLD_LAST) level_d = 2'd0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         level_q <= 2'd0;
         hold_q  <= '0;
      end else begin
         level_q <= level_d;
         hold_q  <= hold_d;
      end
   end

   // Output logic
   always_comb begin
      lane_run         = (state_q == ST_RUN);
      lane_clear       = (state_q == ST_IDLE) || lvl_up_take;
      bus.state        = state_q;
      bus.level        = level_q;
      bus.crash_active = (state_q == ST_CRASH);
      bus.shift_en     = lane_strobe;
   end

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      logic [PERIOD_W-1:0] period;
      assign period = lane_period(BASE_W, LANE_MULT[i], level_q);

      lane_timer u_lane_timer (
         .clk     (clk),
         .reset_n (reset_n),
         .run     (lane_run),
         .clear   (lane_clear),
         .period  (period),
         .strobe  (lane_strobe[i])
      );
   end

endmodule

// File: tb/tb_traffic_scheduler.sv
// tb/tb_traffic_scheduler.sv - scoreboard bench for traffic_scheduler
module tb_traffic_scheduler;

   typedef struct {
      logic [10:0] exp;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   logic [1:0] p_state [8];
   logic [5:0] p_shift [8];

   traffic_scheduler_if bus();

   traffic_scheduler #(.BASE_PERIOD(4), .CRASH_HOLD(3)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Outputs are sampled on the falling edge; each queued entry is the
   // expected output for the cycle in which it was pushed.
   initial begin : monitor
      exp_t       e;
      logic [10:0] act;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = {bus.state, bus.level, bus.shift_en, bus.crash_active};
            checks++;
            if (act !== e.exp) begin
               errors++;
               $display("FAIL %s: got state=%0d level=%0d shift_en=%h crash=%b, expected state=%0d level=%0d shift_en=%h crash=%b",
                        e.name, act[10:9], act[8:7], act[6:1], act[0],
                        e.exp[10:9], e.exp[8:7], e.exp[6:1], e.exp[0]);
            end
         end
      end
   end

   // Drive inputs for the coming edge and queue the outputs expected now.
   task automatic step(input bit rn, input bit st, input bit pa, input bit co, input bit lu,
                       input logic [1:0] es, input logic [1:0] el, input logic [5:0] esh,
                       input logic ec, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      reset_n      = rn;
      bus.start    = st;
      bus.pause    = pa;
      bus.collide  = co;
      bus.level_up = lu;
      e.exp  = {es, el, esh, ec};
      e.name = nm;
      sb_q.push_back(e);
   endtask

   initial begin : stimulus
      bus.start = 1'b0; bus.pause = 1'b0; bus.collide = 1'b0; bus.level_up = 1'b0;

`ifdef TRAFFIC_SCHED_PAUSE_EN
      p_state = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1};
      p_shift = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h37};
`else
      p_state = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
      p_shift = '{6'h00, 6'h00, 6'h37, 6'h00, 6'h00, 6'h00, 6'h25, 6'h00};
`endif

      step(0, 0, 0, 0, 0, 2'd0, 2'd0, 6'h00, 1'b0, "reset");
      step(1, 1, 0, 0, 0, 2'd0, 2'd0, 6'h00, 1'b0, "idle_start");

      // Level 0 periods: lanes 0,2,5 = 4, lanes 1,4 = 8, lane 3 = 12.
      for (int k = 1; k <= 12; k++) begin
         logic [5:0] e;
         e = 6'h00;
         if (k % 4 == 0)  e = e | 6'h25;
         if (k % 8 == 0)  e = e | 6'h12;
         if (k % 12 == 0) e = e | 6'h08;
         step(1, 0, 0, 0, 0, 2'd1, 2'd0, e, 1'b0, $sformatf("run_c%0d", k));
      end

      step(1, 0, 1, 0, 0, 2'd1, 2'd0, 6'h00, 1'b0, "pause_enter");
      for (int k = 0; k < 8; k++)
         step(1, 0, (k < 4), 0, (k == 7), p_state[k], 2'd0, p_shift[k], 1'b0,
              $sformatf("pause_phase_%0d", k));

      step(1, 0, 0, 0, 0, 2'd1, 2'd1, 6'h00, 1'b0, "lvl1_c1");
      step(1, 0, 0, 0, 0, 2'd1, 2'd1, 6'h25, 1'b0, "lvl1_c2");
      step(1, 0, 0, 0, 0, 2'd1, 2'd1, 6'h00, 1'b0, "lvl1_c3");
      step(1, 0, 0, 0, 1, 2'd1, 2'd1, 6'h37, 1'b0, "lvl1_c4");
      step(1, 0, 0, 0, 1, 2'd1, 2'd2, 6'h25, 1'b0, "lvl2_c1");
      step(1, 0, 0, 0, 1, 2'd1, 2'd3, 6'h3F, 1'b0, "lvl3_c1");
      step(1, 0, 0, 0, 1, 2'd1, 2'd3, 6'h3F, 1'b0, "lvl3_sat");
      step(1, 0, 1, 1, 0, 2'd1, 2'd3, 6'h3F, 1'b0, "collide_pause");

      step(1, 0, 0, 0, 0, 2'd3, 2'd3, 6'h00, 1'b1, "crash_1");
      step(1, 0, 0, 0, 0, 2'd3, 2'd3, 6'h00, 1'b1, "crash_2");
      step(1, 0, 0, 0, 0, 2'd3, 2'd3, 6'h00, 1'b1, "crash_3");
      step(1, 1, 0, 0, 0, 2'd0, 2'd0, 6'h00, 1'b0, "crash_exit");

      step(1, 0, 0, 0, 1, 2'd1, 2'd0, 6'h00, 1'b0, "rerun_1");
      step(1, 0, 0, 0, 0, 2'd1, 2'd1, 6'h00, 1'b0, "rerun_2");
      step(0, 0, 0, 0, 0, 2'd0, 2'd0, 6'h00, 1'b0, "reset_mid_run");
      step(0, 0, 0, 0, 0, 2'd0, 2'd0, 6'h00, 1'b0, "reset_held");

      step(1, 1, 0, 0, 0, 2'd0, 2'd0, 6'h00, 1'b0, "rerelease");
      step(1, 0, 0, 0, 1, 2'd1, 2'd0, 6'h00, 1'b0, "z_run_1");
      step(1, 0, 0, 1, 0, 2'd1, 2'd1, 6'h00, 1'b0, "z_run_2");
      step(1, 0, 0, 0, 0, 2'd3, 2'd1, 6'h00, 1'b1, "z_crash_entry");
      step(0, 0, 0, 0, 0, 2'd0, 2'd0, 6'h00, 1'b0, "reset_mid_crash");
      step(1, 0, 0, 0, 0, 2'd0, 2'd0, 6'h00, 1'b0, "final_idle");

      for (int w = 0; w < 10 && sb_q.size() > 0; w++)
         @(posedge clk);
      if (sb_q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/traffic_scheduler.md
TRAFFIC_SCHEDULER -- requirements
Module: traffic_scheduler

Interface
REQ-001 Parameter BASE_PERIOD, default 3000: lane-0 shift period in clocks at level 0.
REQ-002 Parameter CRASH_HOLD, default 50000: clocks spent frozen in CRASH before returning to IDLE.
REQ-003 Port clk  input  1: single clock; all state updates on posedge clk.
REQ-004 Port reset_n  input  1: asynchronous, active-low reset.
REQ-005 Port start  input  1: level; requests a new game from IDLE.
REQ-006 Port pause  input  1: level; high holds play frozen while in RUN/PAUSED.
REQ-007 Port collide  input  1: level; frog/car overlap from collision logic.
REQ-008 Port level_up  input  1: one-cycle pulse; requests a speed increase.
REQ-009 Port shift_en  output  6: one-cycle per-lane shift strobes; bit order rows 2,5,7,9,11,12 = bits 0..5.
REQ-010 Port state  output  2: current FSM state encoding.
REQ-011 Port level  output  2: current speed level 0..3.
REQ-012 Port crash_active  output  1: high exactly while state is CRASH.

Function
REQ-013 FSM states SHALL be IDLE=0, RUN=1, PAUSED=2, CRASH=3.
REQ-014 IDLE: start high -> RUN next cycle; all lane counters cleared to 0; level held at 0.
REQ-015 RUN: collide high -> CRASH; else pause high -> PAUSED; else stay (collide beats pause beats level_up in the same cycle).
REQ-016 PAUSED: pause low -> RUN; counters and level held; collide and level_up ignored.
REQ-017 CRASH: 20-bit hold counter cleared on entry, increments each cycle; at CRASH_HOLD-1 -> IDLE with level cleared to 0.
REQ-018 Per-lane period SHALL be (BASE_PERIOD * LANE_MULT[i]) >> level, computed at 24-bit width; a result below 1 is clamped to 1.
REQ-019 Each lane counter (20 bits) SHALL increment only in RUN, wrap to 0 after reaching period-1.
REQ-020 shift_en[i] SHALL be high, combinationally from registered state, only in the RUN cycle where lane-i counter equals period-1; never in IDLE, PAUSED, or CRASH.
REQ-021 level_up in RUN SHALL increment level, saturating at 3; every lane counter is cleared to 0 in the same edge (a strobe due that cycle still fires).
REQ-022 level_up at level 3 SHALL produce no level change and no counter clear.
REQ-023 Multiple lanes MAY strobe in the same cycle; there is no arbitration between lanes.

Reset
REQ-024 reset_n low SHALL immediately force state=IDLE, level=0, all lane and hold counters=0, shift_en=0, crash_active=0, asserted mid-operation in any state.
REQ-025 The first state change after reset release SHALL occur on the first posedge clk with reset_n high.

Configuration
REQ-026 Macro TRAFFIC_SCHED_PAUSE_EN defined: pause behaves per REQ-015/016.
REQ-027 Macro TRAFFIC_SCHED_PAUSE_EN undefined: pause port remains but is ignored; PAUSED is unreachable; state encoding unchanged.

Structure
REQ-028 Package traffic_pkg SHALL hold the state enum type, NUM_LANES=6, and the LANE_MULT constant array {1,2,1,3,2,1} (lane 0..5).
REQ-029 Sub-module lane_timer (one per lane, generate loop) SHALL hold one lane counter, with inputs run, clear, period and output strobe.

Verification (BASE_PERIOD=4, CRASH_HOLD=3, PAUSE_EN defined)
REQ-030 Reset then start pulse -> RUN next cycle; shift_en[0] high on the 4th RUN cycle, then every 4 cycles; shift_en[3] first high on the 12th cycle.
REQ-031 level_up at level 0 -> level=1, lane-0 period 2, first strobe 2 cycles later; four level_up pulses leave level=3 with lane-0 period clamped to 1 (strobe every cycle).
REQ-032 pause high for 5 cycles in RUN -> state=2, shift_en=0 throughout; release -> counters resume from held values.
REQ-033 collide and pause high together in RUN -> CRASH, crash_active high for exactly 3 cycles, then IDLE with level=0.
REQ-034 reset_n low mid-CRASH and mid-RUN -> all outputs 0 and state IDLE immediately, without waiting for clk.
REQ-035 PAUSE_EN undefined build: pause high in RUN -> state stays 1 and strobes continue.
